// File: rtl/instruction_fetcher_pkg.sv
// rtl/instruction_fetcher_pkg.sv - shared opcode constants, reset PC and prediction helpers for the fetcher
//
// Contents:
//   RESET_PC_DEFAULT  default architectural fetch PC after reset
//   OPC_*             RV32 major opcodes the static predictor recognises
//   pred_kind_e       which next-PC rule applies to an instruction
//   classify          maps (opcode, immediate sign) to a pred_kind_e
package instruction_fetcher_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        PRED_FALLTHROUGH = 2'd0,
        PRED_JUMP        = 2'd1,
        PRED_BRANCH_BACK = 2'd2
    } pred_kind_e;

    // imm_sign is inst[31], which is the sign bit of both the J and B immediates.
    function automatic pred_kind_e classify(input logic [6:0] opcode, input logic imm_sign);
        pred_kind_e kind;
        kind = PRED_FALLTHROUGH;
        case (opcode)
            OPC_JAL:    kind = PRED_JUMP;
            OPC_BRANCH: kind = imm_sign ? PRED_BRANCH_BACK : PRED_FALLTHROUGH;
            // Register-indirect targets are unknown at fetch, so JALR falls through.
            OPC_JALR:   kind = PRED_FALLTHROUGH;
            default:    kind = PRED_FALLTHROUGH;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/branch_predictor_static.sv
// rtl/branch_predictor_static.sv - combinational static next-PC predictor (JAL taken, backward branches taken)
//
// Ports:
//   pc          PC of the instruction being predicted
//   inst        decompressed 32-bit instruction at pc
//   compressed  original encoding was 16-bit (fallthrough is pc+2 instead of pc+4)
//   pred_pc     predicted next PC, 32-bit wraparound
module branch_predictor_static
    import instruction_fetcher_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    input  logic            compressed,
    output logic [XLEN-1:0] pred_pc
);

    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] fallthrough;
    pred_kind_e      kind;

    // Immediates are sign-extended from inst[31] (imm[20] for J, imm[12] for B).
    assign j_imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b_imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    assign fallthrough = pc + (compressed ? XLEN'(2) : XLEN'(4));
    assign kind        = classify(inst[6:0], inst[31]);

    always_comb begin
        pred_pc = fallthrough;
        case (kind)
            PRED_JUMP:        pred_pc = pc + j_imm;
            PRED_BRANCH_BACK: pred_pc = pc + b_imm;
            default:          pred_pc = fallthrough;
        endcase
    end

endmodule

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - fetch PC owner between icache and decode with static prediction and redirect
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   icache_req_pc             PC requested from the icache (the pc register)
//   icache_inst/valid/compressed  response to the previous cycle's request
//   redirect_en, redirect_pc  flush and restart fetch at redirect_pc (bit 0 forced to 0)
//   out_valid/out_ready       one-entry output register handshake to decode
//   out_inst, out_pc, out_pred_pc, out_compressed  captured instruction and its PCs
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    output logic [XLEN-1:0] icache_req_pc,
    input  logic [XLEN-1:0] icache_inst,
    input  logic            icache_valid,
    input  logic            icache_compressed,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pred_pc,
    output logic            out_compressed
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_stable_q, pc_stable_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_pred_pc_q, out_pred_pc_d;
    logic            out_compressed_q, out_compressed_d;

    logic [XLEN-1:0] pred_pc;
    logic            accept;

    branch_predictor_static #(
        .XLEN (XLEN)
    ) u_bpred (
        .pc         (pc_q),
        .inst       (icache_inst),
        .compressed (icache_compressed),
        .pred_pc    (pred_pc)
    );

    // The icache answers last cycle's request, so its data only matches pc_q
    // when pc_q did not move on the previous edge.
    assign accept = pc_stable_q & icache_valid & (~out_valid_q | out_ready) & ~redirect_en;

    always_comb begin
        pc_d             = pc_q;
        pc_stable_d      = 1'b1;
        out_valid_d      = out_valid_q;
        out_inst_d       = out_inst_q;
        out_pc_d         = out_pc_q;
        out_pred_pc_d    = out_pred_pc_q;
        out_compressed_d = out_compressed_q;

        if (redirect_en) begin
            // Masking rather than slicing keeps every redirect_pc bit in use.
            pc_d        = redirect_pc & ~XLEN'(1);
            pc_stable_d = 1'b0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            pc_d             = pred_pc;
            pc_stable_d      = 1'b0;
            out_valid_d      = 1'b1;
            out_inst_d       = icache_inst;
            out_pc_d         = pc_q;
            out_pred_pc_d    = pred_pc;
            out_compressed_d = icache_compressed;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q             <= RESET_PC;
            pc_stable_q      <= 1'b0;
            out_valid_q      <= 1'b0;
            out_inst_q       <= '0;
            out_pc_q         <= '0;
            out_pred_pc_q    <= '0;
            out_compressed_q <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            pc_stable_q      <= pc_stable_d;
            out_valid_q      <= out_valid_d;
            out_inst_q       <= out_inst_d;
            out_pc_q         <= out_pc_d;
            out_pred_pc_q    <= out_pred_pc_d;
            out_compressed_q <= out_compressed_d;
        end
    end

    assign icache_req_pc  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_inst       = out_inst_q;
    assign out_pc         = out_pc_q;
    assign out_pred_pc    = out_pred_pc_q;
    assign out_compressed = out_compressed_q;

endmodule
